// File: rtl/state_estimate_updater.sv
// Kalman state-estimate engine: x_pred = A*x_hat + B*u, innov = y - C*x_pred, x_hat = x_pred + K*innov.
// Latency: prediction nos*(nos+nin) enabled cycles, update noo*nos + nos*noo enabled cycles, one MAC per cycle.
// Backpressure: clk_en=0 freezes everything; Start_* requests are ignored while busy. Build option: STATE_EST_SAT_EN.
module state_estimate_updater #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int nos   = 4,
    parameter int noo   = 2,
    parameter int nin   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    Start_Prediction,
    input  logic                    Start_Update,
    input  logic signed [WIDTH-1:0] A      [nos][nos],
    input  logic signed [WIDTH-1:0] B      [nos][nin],
    input  logic signed [WIDTH-1:0] C      [noo][nos],
    input  logic signed [WIDTH-1:0] K      [nos][noo],
    input  logic signed [WIDTH-1:0] u      [nin],
    input  logic signed [WIDTH-1:0] y      [noo],
    input  logic signed [WIDTH-1:0] x0     [nos],
    output logic signed [WIDTH-1:0] x_hat  [nos],
    output logic signed [WIDTH-1:0] x_pred [nos],
    output logic signed [WIDTH-1:0] innov  [noo],
    output logic                    busy,
    output logic                    end_Prediction,
    output logic                    end_Update
);

    localparam int ACC_W = 2*WIDTH + $clog2(nos+nin) + 1;
    localparam int IW    = $clog2(nos+nin+noo+1);

    localparam logic [IW-1:0] PRED_LC = IW'(nos+nin-1);
    localparam logic [IW-1:0] INNO_LC = IW'(nos-1);
    localparam logic [IW-1:0] CORR_LC = IW'(noo-1);
    localparam logic [IW-1:0] NOS_LR  = IW'(nos-1);
    localparam logic [IW-1:0] NOO_LR  = IW'(noo-1);

    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PRED, PRED_DONE, INNOV, CORR, UPD_DONE} state_t;

    state_t                  state;
    logic [IW-1:0]           row, col;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] u_reg [nin];
    logic signed [WIDTH-1:0] y_reg [noo];

    logic signed [WIDTH-1:0]   op_a, op_b, y_sel, xp_sel;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [WIDTH-1:0]   mac_res, innov_val, corr_val;
    logic signed [WIDTH:0]     innov_sum, corr_sum;
    logic                      last_c, last_r;

    // Narrow a wide signed value to WIDTH bits: saturate or two's-complement wrap.
    function automatic logic signed [WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef STATE_EST_SAT_EN
        if (v > MAXV)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < MINV)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return WIDTH'(v);
`else
        return WIDTH'(v);
`endif
    endfunction

    // MAC operand selection, accumulate, and per-phase row results.
    always_comb begin
        op_a   = '0;
        op_b   = '0;
        y_sel  = '0;
        xp_sel = '0;
        last_c = 1'b0;
        last_r = 1'b0;
        case (state)
            PRED: begin
                for (int i = 0; i < nos; i++) begin
                    for (int c = 0; c < nos; c++)
                        if (row == IW'(i) && col == IW'(c)) begin
                            op_a = A[i][c];
                            op_b = x_hat[c];
                        end
                    for (int k = 0; k < nin; k++)
                        if (row == IW'(i) && col == IW'(nos+k)) begin
                            op_a = B[i][k];
                            op_b = u_reg[k];
                        end
                end
                last_c = (col == PRED_LC);
                last_r = (row == NOS_LR);
            end
            INNOV: begin
                for (int r = 0; r < noo; r++) begin
                    for (int c = 0; c < nos; c++)
                        if (row == IW'(r) && col == IW'(c)) begin
                            op_a = C[r][c];
                            op_b = x_pred[c];
                        end
                    if (row == IW'(r))
                        y_sel = y_reg[r];
                end
                last_c = (col == INNO_LC);
                last_r = (row == NOO_LR);
            end
            CORR: begin
                for (int i = 0; i < nos; i++) begin
                    for (int r = 0; r < noo; r++)
                        if (row == IW'(i) && col == IW'(r)) begin
                            op_a = K[i][r];
                            op_b = innov[r];
                        end
                    if (row == IW'(i))
                        xp_sel = x_pred[i];
                end
                last_c = (col == CORR_LC);
                last_r = (row == NOS_LR);
            end
            default: ;
        endcase
        prod      = op_a * op_b;
        acc_sum   = ((col == '0) ? '0 : acc) + ACC_W'(prod);
        mac_res   = narrow(acc_sum >>> FRAC);
        innov_sum = (WIDTH+1)'(y_sel) - (WIDTH+1)'(mac_res);
        corr_sum  = (WIDTH+1)'(xp_sel) + (WIDTH+1)'(mac_res);
        innov_val = narrow(ACC_W'(innov_sum));
        corr_val  = narrow(ACC_W'(corr_sum));
    end

    // Control FSM, index counters, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                state          <= IDLE;
                x_hat          <= x0;
                x_pred         <= x0;
                for (int r = 0; r < noo; r++) innov[r] <= '0;
                for (int r = 0; r < noo; r++) y_reg[r] <= '0;
                for (int k = 0; k < nin; k++) u_reg[k] <= '0;
                acc            <= '0;
                row            <= '0;
                col            <= '0;
                busy           <= 1'b0;
                end_Prediction <= 1'b0;
                end_Update     <= 1'b0;
            end else begin
                case (state)
                    IDLE, PRED_DONE, UPD_DONE: begin
                        // PRED_DONE favours a pending update; IDLE and UPD_DONE favour prediction.
                        if (state == PRED_DONE && Start_Update) begin
                            state          <= INNOV;
                            y_reg          <= y;
                            row            <= '0;
                            col            <= '0;
                            busy           <= 1'b1;
                            end_Prediction <= 1'b0;
                            end_Update     <= 1'b0;
                        end else if (Start_Prediction) begin
                            state          <= PRED;
                            u_reg          <= u;
                            row            <= '0;
                            col            <= '0;
                            busy           <= 1'b1;
                            end_Prediction <= 1'b0;
                            end_Update     <= 1'b0;
                        end else if (state == IDLE && Start_Update) begin
                            state          <= INNOV;
                            y_reg          <= y;
                            row            <= '0;
                            col            <= '0;
                            busy           <= 1'b1;
                        end
                    end
                    PRED, INNOV, CORR: begin
                        acc <= acc_sum;
                        if (last_c) begin
                            col <= '0;
                            for (int i = 0; i < nos; i++)
                                if (row == IW'(i)) begin
                                    if (state == PRED) x_pred[i] <= mac_res;
                                    if (state == CORR) x_hat[i]  <= corr_val;
                                end
                            for (int r = 0; r < noo; r++)
                                if (row == IW'(r) && state == INNOV) innov[r] <= innov_val;
                            if (last_r) begin
                                row <= '0;
                                if (state == PRED) begin
                                    state          <= PRED_DONE;
                                    busy           <= 1'b0;
                                    end_Prediction <= 1'b1;
                                end else if (state == INNOV) begin
                                    state <= CORR;
                                end else begin
                                    state      <= UPD_DONE;
                                    busy       <= 1'b0;
                                    end_Update <= 1'b1;
                                end
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/state_estimate_updater.md
# state_estimate_updater

Fixed-point Kalman state-estimate engine, the direct consumer of the Kalman gain K produced by the covariance/gain generator. It performs the time update of the state estimate, x_p = A·x + B·u, and the measurement update, e = y − C·x_p and x = x_p + K·e. It shares the Start_Prediction/Start_K_G-style handshake cadence of the covariance block. A single time-shared signed multiply-accumulate unit computes one product per enabled cycle.

## Interface
Parameters:
- WIDTH, 16, signed fixed-point word width of all matrix/vector elements
- FRAC, 8, fractional bits (1.0 = 2^FRAC)
- nos, 4, number of states
- noo, 2, number of outputs
- nin, 1, number of inputs

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled only when clk_en=1
- clk_en  in  1  global clock enable; when 0 every register holds
- Start_Prediction  in  1  request time update
- Start_Update  in  1  request measurement update (K must be valid)
- A  in  [WIDTH-1:0][nos][nos]  state matrix
- B  in  [WIDTH-1:0][nos][nin]  input matrix
- C  in  [WIDTH-1:0][noo][nos]  output matrix
- K  in  [WIDTH-1:0][nos][noo]  Kalman gain (t2 of covariance block)
- u  in  [WIDTH-1:0][nin]  input vector
- y  in  [WIDTH-1:0][noo]  measurement vector
- x0  in  [WIDTH-1:0][nos]  initial estimate
- x_hat  out  [WIDTH-1:0][nos]  corrected estimate x(nk/nk)
- x_pred  out  [WIDTH-1:0][nos]  predicted estimate x(nk/nk-1)
- innov  out  [WIDTH-1:0][noo]  innovation e
- busy  out  1  high in PRED, INNOV, CORR
- end_Prediction  out  1  level, high in PRED_DONE
- end_Update  out  1  level, high in UPD_DONE

## Operation
- States: IDLE, PRED, PRED_DONE, INNOV, CORR, UPD_DONE.
- IDLE: Start_Prediction → PRED; otherwise Start_Update → INNOV. Both asserted at once: prediction wins.
- PRED_DONE: Start_Update → INNOV; Start_Prediction → PRED (restart prediction). Otherwise hold.
- UPD_DONE: Start_Prediction → PRED; otherwise hold. Start_Update is ignored.
- Start inputs are ignored while busy.
- On accepting Start_Prediction, u is captured into an internal register. On accepting Start_Update, y is captured.
- PRED: row i = 0..nos-1, column c = 0..nos+nin-1.
  - MAC operand: A[i][c]·x_hat[c] for c < nos, else B[i][c−nos]·u_reg[c−nos].
  - Accumulator is cleared at c = 0. At the last c, the rounded result is written to x_pred[i].
- INNOV: row r = 0..noo-1, c = 0..nos-1, accumulating C[r][c]·x_pred[c]. At the last c, innov[r] = y_reg[r] − result.
- CORR: row i, r = 0..noo-1, accumulating K[i][r]·innov[r]. At the last r, x_hat[i] = x_pred[i] + result.
  - INNOV → CORR and CORR → UPD_DONE occur automatically on the last MAC.
- Arithmetic:
  - Products are full 2·WIDTH signed.
  - Accumulator is 2·WIDTH + clog2(nos+nin) + 1 bits.
  - Result = accumulator >>> FRAC (arithmetic shift, truncation toward −∞), then narrowed to WIDTH per the Configuration section.
  - Additions and subtractions in INNOV/CORR are WIDTH+1 bits and are narrowed the same way.
- Update from IDLE (no prior prediction) uses the current x_pred, which is x0 after reset.

## Timing
- Reset (clk_en=1) sets:
  - state = IDLE
  - x_hat = x0 and x_pred = x0
  - innov = 0
  - accumulator and indices = 0
  - busy = 0, end_Prediction = 0, end_Update = 0
- Reset mid-operation aborts immediately with the same values.
- Every cycle count below is in clk_en=1 cycles. A clk_en=0 cycle freezes all state, indices and outputs.
- PRED: nos·(nos+nin) cycles (20 at defaults). end_Prediction rises on the edge that completes the final MAC, i.e. 20 edges after the accepting edge.
- Update: noo·nos + nos·noo cycles (16 at defaults). end_Update rises 16 edges after the accepting edge.
- Each x_pred[i] / x_hat[i] changes only on its own row-completion edge. Outputs are otherwise stable.
- x_hat is not modified in PRED, so PRED reads a consistent vector.

## Configuration
- STATE_EST_SAT_EN defined: every narrowing to WIDTH saturates to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
- STATE_EST_SAT_EN undefined: narrowing keeps the low WIDTH bits (two's-complement wrap).
- No other behaviour differs between the two builds.

## Test plan
All scenarios use the defaults: WIDTH=16, FRAC=8, nos=4, noo=2, nin=1.
- Reset then identity prediction: x0=[256,512,−256,0], A=I (256 on diagonal), B=0. Pulse Start_Prediction → end_Prediction high exactly 20 edges later; x_pred=[256,512,−256,0]; busy high for those 20 cycles.
- Input term: A=0, B=[256,512,0,−128], u=[512] → x_pred=[512,1024,0,−256].
- Measurement update: x_pred=[256,0,0,0], C row0=[256,0,0,0], C row1=0, y=[768,0], K[i][0]=128, K[i][1]=0.
  - Required response: innov=[512,0]; x_hat=[512,256,256,256]; end_Update exactly 16 edges after the accepting edge.
- Saturation: A=diag(512), x0[0]=0x7F00.
  - With STATE_EST_SAT_EN → x_pred[0]=0x7FFF.
  - Without → x_pred[0]=0xFE00.
- Control corner cases:
  - clk_en held low 5 cycles mid-PRED → end_Prediction delayed by exactly 5 cycles, results unchanged.
  - Start_Prediction and Start_Update together in IDLE → PRED entered.
  - Starts asserted while busy are ignored.
- Reset in the middle of CORR → next edge: state IDLE, x_hat=x0, innov=0, all status outputs 0.
